keypad_encoder: RTL and testbench

Scans a 4x4 matrix keypad, debounces it, and emits one single-cycle key event per physical press on the 5-bit `pressed_button` bus. The bus is `{valid, code[3:0]}`, and code 4'hF means "clear". This block is the producer side of the keypad event interface consumed by the price-entry logic. It sits between the board keypad pins and that consumer.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_if.sv | 19 +
 rtl/keypad_encoder_row_sync.sv | 22 ++
 rtl/keypad_encoder.sv | 126 ++++++++++++
 tb/tb_keypad_encoder.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_encoder shared types, key codes and the {row,col} key map.
// Also holds small helpers for column drive and row priority.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_RELEASE
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hF;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  // Indexed {row, col}; entry 0 is row0/col0.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    KEY_CLEAR, 4'h0, KEY_ENTER, 4'hD
  };

  function automatic logic [3:0] col_drive(
    input logic [1:0] idx
  );
    return ~(4'b0001 << idx);
  endfunction

  // Lowest-index low row wins.
  function automatic logic [1:0] first_low(
    input logic [3:0] r
  );
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pins plus the key event bus.
// master: encoder side (drives col, pressed_button); slave: consumer.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] pressed_button;

  modport master (
    input  row,
    output col,
    output pressed_button
  );

  modport slave (
    output row,
    input  col,
    input  pressed_button
  );
endinterface

// File: rtl/keypad_encoder_row_sync.sv
// 4-bit two-flop synchronizer for the keypad rows.
// Ports: clock, reset (async, high), row_a in, row_s out; resets to 4'hF.
module row_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_a,
  output logic [3:0] row_s
);

  logic [3:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta  <= 4'hF;
      row_s <= 4'hF;
    end else begin
      meta  <= row_a;
      row_s <= meta;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner/debouncer emitting one strobe per press.
// Ports: clock, reset (async, high), kp (keypad_if.master).
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic     clock,
  input  logic     reset,
  keypad_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_MAX =
    DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_N =
    CW'(DEBOUNCE);

  logic [3:0]    row_s;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [1:0]    col_idx;
  logic [1:0]    cand;
  logic [3:0]    col_q;
  logic [4:0]    pb_q;
  state_t        state;

  logic          sample;
  logic          all_high;
  logic          cand_low;
  logic [CW-1:0] cnt_inc;
  logic          cnt_last;
  logic [1:0]    nxt_idx;
  logic [1:0]    hit_row;

  row_sync u_sync (
    .clock (clock),
    .reset (reset),
    .row_a (kp.row),
    .row_s (row_s)
  );

  assign sample   = (div == DIV_MAX);
  assign all_high = (row_s == 4'hF);
  assign cand_low = ~row_s[cand];
  assign cnt_inc  = cnt + CW'(1);
  assign cnt_last = (cnt_inc == DB_N);
  assign nxt_idx  = col_idx + 2'd1;
  assign hit_row  = first_low(row_s);

  assign kp.col            = col_q;
  assign kp.pressed_button = pb_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_SCAN;
      div     <= '0;
      cnt     <= '0;
      col_idx <= 2'd0;
      cand    <= 2'd0;
      col_q   <= 4'b1110;
      pb_q    <= 5'b0;
    end else begin
      div  <= sample ? '0 : div + DW'(1);
      pb_q <= 5'b0;
      unique case (state)
        ST_SCAN: begin
          if (sample) begin
            if (all_high) begin
              col_idx <= nxt_idx;
              col_q   <= col_drive(nxt_idx);
            end else begin
              cand <= hit_row;
              cnt  <= CW'(1);
              if (DEBOUNCE == 1) begin
                state <= ST_EMIT;
                pb_q  <= {1'b1,
                  KEY_MAP[{hit_row, col_idx}]};
              end else begin
                state <= ST_DEBOUNCE;
              end
            end
          end
        end
        ST_DEBOUNCE: begin
          if (sample) begin
            if (cand_low) begin
              cnt <= cnt_inc;
              if (cnt_last) begin
                state <= ST_EMIT;
                pb_q  <= {1'b1,
                  KEY_MAP[{cand, col_idx}]};
              end
            end else begin
              state   <= ST_SCAN;
              col_idx <= nxt_idx;
              col_q   <= col_drive(nxt_idx);
            end
          end
        end
        ST_EMIT: begin
          state <= ST_RELEASE;
          cnt   <= '0;
        end
        ST_RELEASE: begin
          if (sample) begin
            if (all_high) begin
              cnt <= cnt_inc;
              if (cnt_last) begin
                state   <= ST_SCAN;
                col_idx <= nxt_idx;
                col_q   <= col_drive(nxt_idx);
              end
            end else begin
              cnt <= '0;
            end
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with a behavioural keypad model.
// SCAN_DIV=4, DEBOUNCE=3.
module tb_keypad_encoder;

  logic        clock;
  logic        reset;
  logic [15:0] keys;
  int          total;
  int          bad;
  int          cyc;
  int          col_bad;
  int          pb_bad;
  logic [4:0]  ev_q [$];
  int          ev_t [$];

  keypad_if kp ();

  keypad_encoder #(
    .SCAN_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Key at {r,c} pulls row r low while column c is driven low.
  always_comb begin
    kp.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.col[c])
          kp.row[r] = 1'b0;
  end

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if ($countones(~kp.col) != 1)
      col_bad <= col_bad + 1;
    if (kp.pressed_button[4]) begin
      ev_q.push_back(kp.pressed_button);
      ev_t.push_back(cyc);
    end else if (kp.pressed_button != 5'b0) begin
      pb_bad <= pb_bad + 1;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
        tag, obs, exp);
    end
  endtask

  task automatic press(
    input int k,
    input int hold,
    input int gap
  );
    keys[k] = 1'b1;
    repeat (hold) @(negedge clock);
    keys[k] = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic wait_col(input logic [3:0] t);
    int n;
    n = 0;
    while (kp.col === t && n < 100) begin
      @(negedge clock);
      n++;
    end
    while (kp.col !== t && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("wait_col", 32'(n < 100), 32'd1);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    col_bad = 0;
    pb_bad  = 0;
    keys    = '0;
    reset   = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_col", 32'(kp.col), 32'h0000000E);
    chk("rst_pb", 32'(kp.pressed_button), 32'h0);

    reset = 1'b0;
    repeat (9) @(negedge clock);
    chk("scan_col2", 32'(kp.col), 32'h0000000B);
    reset = 1'b1;
    #1;
    chk("async_col", 32'(kp.col), 32'h0000000E);
    chk("async_pb", 32'(kp.pressed_button), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    ev_q.delete(); ev_t.delete();
    keys[5] = 1'b1;
    repeat (100) @(negedge clock);
    chk("hold5_col", 32'(kp.col), 32'h0000000D);
    keys[5] = 1'b0;
    repeat (4) @(negedge clock);
    chk("rel5_col", 32'(kp.col), 32'h0000000D);
    repeat (40) @(negedge clock);
    chk("k5_n", 32'(ev_q.size()), 32'd1);
    chk("k5_v", 32'(ev_q[0]), 32'h15);

    ev_q.delete(); ev_t.delete();
    press(12, 60, 40);
    press(13, 60, 40);
    chk("star0_n", 32'(ev_q.size()), 32'd2);
    chk("star_v", 32'(ev_q[0]), 32'h1F);
    chk("zero_v", 32'(ev_q[1]), 32'h10);

    ev_q.delete(); ev_t.delete();
    wait_col(4'b1011);
    press(6, 4, 12);
    chk("glitch_n", 32'(ev_q.size()), 32'd0);
    press(6, 60, 40);
    chk("k6_n", 32'(ev_q.size()), 32'd1);
    chk("k6_v", 32'(ev_q[0]), 32'h16);

    ev_q.delete(); ev_t.delete();
    keys[0] = 1'b1;
    keys[4] = 1'b1;
    repeat (60) @(negedge clock);
    keys[0] = 1'b0;
    keys[4] = 1'b0;
    repeat (40) @(negedge clock);
    chk("dual_n", 32'(ev_q.size()), 32'd1);
    chk("dual_v", 32'(ev_q[0]), 32'h11);

    ev_q.delete(); ev_t.delete();
    press(0, 40, 40);
    press(1, 40, 40);
    press(2, 40, 40);
    chk("seq_n", 32'(ev_q.size()), 32'd3);
    chk("seq_v0", 32'(ev_q[0]), 32'h11);
    chk("seq_v1", 32'(ev_q[1]), 32'h12);
    chk("seq_v2", 32'(ev_q[2]), 32'h13);
    chk("seq_gap1",
      32'((ev_t[1] - ev_t[0]) >= 16), 32'd1);
    chk("seq_gap2",
      32'((ev_t[2] - ev_t[1]) >= 16), 32'd1);

    chk("col_onehot", 32'(col_bad), 32'd0);
    chk("pb_idle_zero", 32'(pb_bad), 32'd0);

    $display("test done: total=%0d bad=%0d",
      total, bad);
    $finish;
  end

endmodule
